fb_writeback: RTL
=================

FB_WRITEBACK -- requirements
Module: fb_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width of results and register-file write data.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port mem_valid, input, 1, MEM stage offers a retiring instruction.
REQ-005 SHALL have port mem_ready, output, 1, writeback accepts the offer; a transfer occurs when mem_valid and mem_ready are both high at a rising edge.
REQ-006 SHALL have ports mem_rd (input, 5, destination register), mem_rd_we (input, 1, instruction writes rd), mem_result (input, XLEN, ALU/CSR result), mem_is_load (input, 1), mem_funct3 (input, 3, load type), mem_addr_lo (input, 2, load byte offset).
REQ-007 SHALL have ports dmem_rvalid (input, 1) and dmem_rdata (input, XLEN): data-memory load response.
REQ-008 SHALL have ports rf_we (output, 1), rf_waddr (output, 5), rf_wdata (output, XLEN): drive the register-file write port.
REQ-009 SHALL have ports retire_valid (output, 1, one-cycle pulse per retired instruction), retire_count (output, 32), load_err (output, 1, one-cycle pulse on illegal load type).
REQ-010 SHALL have ports byp_valid (output, 1), byp_rd (output, 5), byp_data (output, XLEN): decode-stage forwarding of the in-flight write.

Function
REQ-011 SHALL implement FSM with states IDLE and WAIT_LOAD; mem_ready = 1 only in IDLE.
REQ-012 IDLE, transfer with mem_is_load=0: next cycle rf_we = mem_rd_we and (mem_rd != 0), rf_waddr = mem_rd, rf_wdata = mem_result, retire_valid = 1; state stays IDLE.
REQ-013 IDLE, transfer with mem_is_load=1: capture rd, rd_we, funct3, addr_lo; go to WAIT_LOAD; no write or retire that cycle.
REQ-014 WAIT_LOAD: dmem_rvalid sampled only in this state; response is never earlier than one cycle after acceptance; wait is unbounded.
REQ-015 WAIT_LOAD with dmem_rvalid=1: next cycle write extracted data per REQ-016, retire_valid = 1, return to IDLE; mem_ready rises in that same next cycle.
REQ-016 Extraction: funct3 000 LB = sign-extend byte addr_lo; 100 LBU = zero-extend byte addr_lo; 001 LH = sign-extend halfword addr_lo[1]; 101 LHU = zero-extend halfword addr_lo[1]; 010 LW = full word, addr_lo ignored.
REQ-017 Any other funct3: rf_we = 0, load_err = 1 for one cycle, retire_valid still 1.
REQ-018 Writes to x0 SHALL never assert rf_we; retire still counted.
REQ-019 rf_we, rf_waddr, rf_wdata, retire_valid, load_err SHALL be registered, asserted exactly one cycle, then rf_we/retire_valid/load_err return to 0; rf_waddr/rf_wdata hold last value.
REQ-020 retire_count SHALL increment by 1 on each retire_valid cycle, wrapping 0xFFFFFFFF -> 0.
REQ-021 Back-to-back non-load transfers SHALL sustain one write per cycle.

Reset
REQ-022 On reset low: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, retire_valid 0, load_err 0, retire_count 0, byp_* 0, immediately and asynchronously.
REQ-023 Reset during WAIT_LOAD SHALL abandon the load with no write and no retire; a dmem_rvalid arriving after reset release in IDLE is ignored.

Configuration
REQ-024 Macro FB_WB_BYPASS_EN defined: byp_valid = rf_we, byp_rd = rf_waddr, byp_data = rf_wdata, combinational from the write registers, same cycle as the write.
REQ-025 FB_WB_BYPASS_EN undefined: byp_valid, byp_rd, byp_data tied to 0; ports remain present.

Structure
REQ-026 Load funct3 encodings, FSM state encoding and XLEN default SHALL reside in the shared package fb_pkg.
REQ-027 Load extraction SHALL be a combinational sub-module fb_load_align (inputs funct3, addr_lo, rdata; outputs data, illegal).

Verification
REQ-028 Non-load: rd=5, rd_we=1, result=0x0000_0004 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x4, retire_count 0->1.
REQ-029 LB: addr_lo=2, rdata=0x0080_0000, rd=8 -> response +1 cycle rf_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr_lo=2, rdata=0x8001_0000 -> 0xFFFF_8001.
REQ-030 Write to rd=0 with result=0xDEAD_BEEF -> rf_we stays 0, retire_valid=1.
REQ-031 Load, reset pulsed in WAIT_LOAD, then dmem_rvalid=1 -> no rf_we, mem_ready=1, retire_count=0.
REQ-032 funct3=011 load -> load_err=1 one cycle, rf_we=0; preset retire_count 0xFFFF_FFFF plus one retire -> 0.
REQ-033 With FB_WB_BYPASS_EN: write rd=8 data 0x4 -> byp_valid=1, byp_rd=8, byp_data=0x4 in rf_we cycle; without it all byp_* stay 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the fb writeback stage: default data width,
// RISC-V load funct3 encodings and the writeback FSM state encoding.
package fb_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/fb_load_align.sv
// Combinational load data extraction: selects the byte/halfword addressed by
// addr_lo and sign- or zero-extends it; flags funct3 values that are not loads.
module fb_load_align
  import fb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data    = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data = rdata;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fb_writeback.sv
// Writeback stage: retires MEM-stage results to the register file, waiting
// for the data-memory response on loads. Optional decode forwarding is
// enabled by defining FB_WB_BYPASS_EN.
module fb_writeback
  import fb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic            mem_rd_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic            mem_is_load,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire_valid,
  output logic [31:0]     retire_count,
  output logic            load_err,
  output logic            byp_valid,
  output logic [4:0]      byp_rd,
  output logic [XLEN-1:0] byp_data
);

  wb_state_e       state_q, state_d;
  logic [4:0]      ld_rd_q;
  logic            ld_we_q;
  logic [2:0]      ld_f3_q;
  logic [1:0]      ld_lo_q;
  logic [XLEN-1:0] ld_data;
  logic            ld_illegal;
  logic            accept;
  logic            ld_done;

  assign accept  = mem_valid && (state_q == ST_IDLE);
  assign ld_done = dmem_rvalid && (state_q == ST_WAIT_LOAD);

  fb_load_align #(.XLEN(XLEN)) u_align (
    .funct3  (ld_f3_q),
    .addr_lo (ld_lo_q),
    .rdata   (dmem_rdata),
    .data    (ld_data),
    .illegal (ld_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_ready = 1'b1;
        if (mem_valid && mem_is_load) state_d = ST_WAIT_LOAD;
      end
      ST_WAIT_LOAD: begin
        if (dmem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load context held while the memory response is outstanding
  always_ff @(posedge clk) begin
    if (accept && mem_is_load) begin
      ld_rd_q <= mem_rd;
      ld_we_q <= mem_rd_we;
      ld_f3_q <= mem_funct3;
      ld_lo_q <= mem_addr_lo;
    end
  end

  // Register-file write port and retire pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_valid <= 1'b0;
      load_err     <= 1'b0;
      retire_count <= '0;
    end else begin
      rf_we        <= 1'b0;
      retire_valid <= 1'b0;
      load_err     <= 1'b0;
      if (accept && !mem_is_load) begin
        rf_we        <= mem_rd_we && (mem_rd != 5'd0);
        rf_waddr     <= mem_rd;
        rf_wdata     <= mem_result;
        retire_valid <= 1'b1;
        retire_count <= retire_count + 32'd1;
      end else if (ld_done) begin
        retire_valid <= 1'b1;
        retire_count <= retire_count + 32'd1;
        if (ld_illegal) begin
          load_err <= 1'b1;
        end else begin
          rf_we    <= ld_we_q && (ld_rd_q != 5'd0);
          rf_waddr <= ld_rd_q;
          rf_wdata <= ld_data;
        end
      end
    end
  end

`ifdef FB_WB_BYPASS_EN
  assign byp_valid = rf_we;
  assign byp_rd    = rf_waddr;
  assign byp_data  = rf_wdata;
`else
  assign byp_valid = 1'b0;
  assign byp_rd    = '0;
  assign byp_data  = '0;
`endif

endmodule
